// File: rtl/smb_serial_ctrl_if.sv
// Bus bundle between the serial message controller and the switch box.
interface smb_serial_ctrl_if;
    logic       serIn;
    logic [1:0] LB;
    logic [3:0] shEn;
    logic       serOut;
    logic       busy;
    logic       done;
    logic [3:0] msgCnt0;
    logic [3:0] msgCnt1;
    logic [3:0] msgCnt2;
    logic [3:0] msgCnt3;

    modport master (
        output serIn,
        input  LB, shEn, serOut, busy, done,
        input  msgCnt0, msgCnt1, msgCnt2, msgCnt3
    );

    modport slave (
        input  serIn,
        output LB, shEn, serOut, busy, done,
        output msgCnt0, msgCnt1, msgCnt2, msgCnt3
    );
endinterface

// File: rtl/smb_serial_ctrl.sv
// Serial message controller: decodes start/address/length/data frames,
// steers the data bits to one of four ports and counts delivered messages.
module smb_serial_ctrl (
    input  logic              clk,
    input  logic              rst,
    smb_serial_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t     state, state_nx;
    logic [1:0] addr_r;
    logic [1:0] lb_r;
    logic [3:0] len_r;
    logic [2:0] bit_cnt;
    logic [3:0] cnt [4];
    logic [3:0] len_shift;
    logic [3:0] shen_c;
    logic       serout_c;
    logic       busy_c;
    logic       done_c;

    assign len_shift = {len_r[2:0], bus.serIn};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode and per-state outputs; outputs forced idle while in reset.
    always_comb begin
        state_nx = state;
        shen_c   = '0;
        serout_c = 1'b0;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.serIn) state_nx = ADDR;
            end
            ADDR: begin
                busy_c = 1'b1;
                if (bit_cnt == 3'd1) state_nx = LEN;
            end
            LEN: begin
                busy_c = 1'b1;
                if (bit_cnt == 3'd3) state_nx = (len_shift != 4'd0) ? DATA : DONE;
            end
            DATA: begin
                busy_c   = 1'b1;
                shen_c   = 4'b0001 << lb_r;
                serout_c = bus.serIn;
                if (len_r == 4'd1) state_nx = DONE;
            end
            DONE: begin
                busy_c   = 1'b1;
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (rst) begin
            shen_c   = '0;
            serout_c = 1'b0;
            busy_c   = 1'b0;
            done_c   = 1'b0;
        end
    end

    // Address/length shift registers, bit counter and per-port message counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= '0;
            lb_r    <= '0;
            len_r   <= '0;
            bit_cnt <= '0;
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            bit_cnt <= (state_nx != state || state == IDLE) ? 3'd0 : bit_cnt + 3'd1;
            case (state)
                ADDR: begin
                    addr_r <= {addr_r[0], bus.serIn};
                    if (bit_cnt == 3'd1) lb_r <= {addr_r[0], bus.serIn};
                end
                LEN:  len_r <= len_shift;
                DATA: len_r <= len_r - 4'd1;
                DONE: cnt[lb_r] <= cnt[lb_r] + 4'd1;
                default: ;
            endcase
        end
    end

    assign bus.LB      = lb_r;
    assign bus.shEn    = shen_c;
    assign bus.serOut  = serout_c;
    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.msgCnt0 = cnt[0];
    assign bus.msgCnt1 = cnt[1];
    assign bus.msgCnt2 = cnt[2];
    assign bus.msgCnt3 = cnt[3];

endmodule

// File: tb/tb_smb_serial_ctrl.sv
// Directed bench for smb_serial_ctrl: per-cycle vector table plus hand
// sequences for mid-frame reset, counter wrap and port switching.
module tb_smb_serial_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   done_seen = 0;

    smb_serial_ctrl_if bus ();

    smb_serial_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        si;
        logic [8:0]  exp;   // {busy, done, shEn, serOut, LB}
        logic [15:0] cnt;   // {msgCnt3, msgCnt2, msgCnt1, msgCnt0}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic si, input logic b, input logic d,
                                input logic [3:0] sh, input logic so, input logic [1:0] lb,
                                input logic [15:0] c);
        vec_t v;
        v.r   = r;
        v.si  = si;
        v.exp = {b, d, sh, so, lb};
        v.cnt = c;
        return v;
    endfunction

    task automatic drive(input logic r, input logic s);
        @(negedge clk);
        rst = r;
        bus.serIn = s;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cnts();
        return {bus.msgCnt3, bus.msgCnt2, bus.msgCnt1, bus.msgCnt0};
    endfunction

    // Sends one frame starting from IDLE; data bits are taken from d[0] upward.
    task automatic send_frame(input logic [1:0] a, input logic [3:0] n, input logic [15:0] d,
                              input logic [1:0] prev_lb, input string tag);
        logic [3:0] oh;
        oh = 4'b0001 << a;
        drive(1'b0, 1'b0);
        chk({tag, " start_idle"}, {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, a[1-i]);
            chk({tag, " lb_during_addr"}, {30'd0, bus.LB}, {30'd0, prev_lb});
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, n[3-i]);
            chk({tag, " lb_after_addr"}, {30'd0, bus.LB}, {30'd0, a});
        end
        for (int i = 0; i < int'(n); i++) begin
            drive(1'b0, d[i]);
            chk({tag, " data_shen_serout"}, {27'd0, bus.shEn, bus.serOut}, {27'd0, oh, d[i]});
        end
        drive(1'b0, 1'b0);  // start bit presented during DONE must be ignored
        chk({tag, " done_pulse"}, {30'd0, bus.busy, bus.done}, 32'd3);
        if (bus.done) done_seen++;
        drive(1'b0, 1'b1);
        chk({tag, " idle_after_done"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        bus.serIn = 1'b1;

        // Frame addr=10, N=3, data 1,0,1
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 2'b00, 16'h0000));
        tbl.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 2'b00, 16'h0000));
        tbl.push_back(mk(0, 0, 1, 0, 4'b0000, 0, 2'b00, 16'h0000));
        tbl.push_back(mk(0, 0, 1, 0, 4'b0000, 0, 2'b10, 16'h0000));
        tbl.push_back(mk(0, 0, 1, 0, 4'b0000, 0, 2'b10, 16'h0000));
        tbl.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 2'b10, 16'h0000));
        tbl.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 2'b10, 16'h0000));
        tbl.push_back(mk(0, 1, 1, 0, 4'b0100, 1, 2'b10, 16'h0000));
        tbl.push_back(mk(0, 0, 1, 0, 4'b0100, 0, 2'b10, 16'h0000));
        tbl.push_back(mk(0, 1, 1, 0, 4'b0100, 1, 2'b10, 16'h0000));
        tbl.push_back(mk(0, 1, 1, 1, 4'b0000, 0, 2'b10, 16'h0000));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 2'b10, 16'h0100));
        // Frame addr=01, N=0: done at cycle 8, busy cycles 2..8
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 2'b10, 16'h0100));
        tbl.push_back(mk(0, 0, 1, 0, 4'b0000, 0, 2'b10, 16'h0100));
        tbl.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 2'b10, 16'h0100));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 1, 0, 4'b0000, 0, 2'b01, 16'h0100));
        tbl.push_back(mk(0, 1, 1, 1, 4'b0000, 0, 2'b01, 16'h0100));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 2'b01, 16'h0110));
        // Reset, then 20 cycles of idle line
        tbl.push_back(mk(1, 1, 0, 0, 4'b0000, 0, 2'b01, 16'h0110));
        for (int i = 0; i < 20; i++)
            tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 2'b00, 16'h0000));

        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        chk("reset_outputs", {23'd0, bus.busy, bus.done, bus.shEn, bus.serOut, bus.LB}, 32'd0);
        chk("reset_counts", {16'd0, cnts()}, 32'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].si);
            chk($sformatf("vec%0d_outputs", i),
                {23'd0, bus.busy, bus.done, bus.shEn, bus.serOut, bus.LB}, {23'd0, tbl[i].exp});
            chk($sformatf("vec%0d_counts", i), {16'd0, cnts()}, {16'd0, tbl[i].cnt});
        end

        // Reset during the 2nd data bit of frame addr=11, N=5
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        chk("abort_first_data", {27'd0, bus.shEn, bus.serOut}, {27'd0, 4'b1000, 1'b1});
        drive(1'b1, 1'b0);
        chk("abort_in_reset", {25'd0, bus.busy, bus.done, bus.shEn, bus.serOut}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1);
            chk($sformatf("abort_idle%0d", i),
                {25'd0, bus.busy, bus.done, bus.shEn, bus.serOut}, 32'd0);
        end
        chk("abort_counts", {16'd0, cnts()}, 32'd0);
        chk("abort_lb", {30'd0, bus.LB}, 32'd0);

        // Sixteen frames to port 0, N=1: counter wraps
        for (int i = 0; i < 16; i++) begin
            send_frame(2'b00, 4'd1, 16'(i & 1), 2'b00, $sformatf("wrap%0d", i));
            if (i == 14) chk("wrap_cnt15", {28'd0, bus.msgCnt0}, 32'd15);
        end
        chk("wrap_cnt0", {16'd0, cnts()}, 32'd0);
        chk("wrap_done_pulses", done_seen, 32'd16);

        // Port 0 then port 3, each N=2
        send_frame(2'b00, 4'd2, 16'b01, 2'b00, "port0");
        send_frame(2'b11, 4'd2, 16'b10, 2'b00, "port3");
        chk("port_counts", {16'd0, cnts()}, {16'd0, 16'h1001});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
